// File: rtl/decoder_pkg.sv
// Shared types for the streaming binary-to-one-hot decoder.
// DECODER_STATS_EN (see decoder_stream) enables the handshake counter that uses STAT_W and sat_inc.
package decoder_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } dec_state_t;

   localparam int unsigned STAT_W = 16;

   // Saturating increment for the statistics counter.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/decoder_skid.sv
// Two-entry skid buffer: main register drives the output, skid register absorbs one extra word
// so the upstream ready can be registered without losing throughput.
module decoder_skid
   import decoder_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_word,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_word,
   output logic             out_valid,
   input  logic             out_ready
);

   dec_state_t       state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             ready_q;
   logic             in_hs;
   logic             out_hs;

   assign in_hs     = in_valid & ready_q;
   assign out_hs    = (state_q != EMPTY) & out_ready;
   assign in_ready  = ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_word  = main_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (in_hs) begin
               state_d = ONE;
               main_d  = in_word;
            end
         end
         ONE: begin
            if (in_hs && !out_hs) begin
               state_d = TWO;
               skid_d  = in_word;
            end else if (out_hs && !in_hs) begin
               state_d = EMPTY;
            end else if (in_hs && out_hs) begin
               main_d = in_word;
            end
         end
         TWO: begin
            // ready is low here, so only the drain side can move
            if (out_hs) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= (state_d != TWO);
      end
   end

endmodule

// File: rtl/decoder_stream.sv
// Streaming binary-to-one-hot decoder with valid/ready on both sides and 1-cycle latency.
// Optional macro DECODER_STATS_EN adds stat_cnt, a saturating count of output handshakes.
module decoder_stream
   import decoder_pkg::*;
#(
   parameter  int unsigned IN_SIZE  = 4,
   localparam int unsigned OUT_SIZE = 1 << IN_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IN_SIZE-1:0]  in_data,
   input  logic                in_enable,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [OUT_SIZE-1:0] out,
   output logic                out_valid,
   input  logic                out_ready
`ifdef DECODER_STATS_EN
   ,
   output logic [STAT_W-1:0]   stat_cnt
`endif
);

   logic [OUT_SIZE-1:0] word;

   // Decoding before the buffer means the buffer only ever stores finished one-hot words.
   always_comb begin
      word = '0;
      if (in_enable) word[in_data] = 1'b1;
   end

   decoder_skid #(
      .WIDTH(OUT_SIZE)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_word  (word),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_word (out),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

`ifdef DECODER_STATS_EN
   logic              out_hs;
   logic [STAT_W-1:0] stat_q;

   assign out_hs   = out_valid & out_ready;
   assign stat_cnt = stat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q <= '0;
      end else if (out_hs) begin
         stat_q <= sat_inc(stat_q);
      end
   end
`endif

endmodule

// File: tb/tb_decoder_stream.sv
// Self-checking bench for decoder_stream: a FIFO-of-words model checked every cycle plus
// directed scenarios with literal expectations.
module tb_decoder_stream;

   localparam int unsigned IN_SIZE  = 4;
   localparam int unsigned OUT_SIZE = 1 << IN_SIZE;

   logic                clk = 1'b0;
   logic                rst;
   logic [IN_SIZE-1:0]  in_data;
   logic                in_enable;
   logic                in_valid;
   logic                in_ready;
   logic [OUT_SIZE-1:0] out;
   logic                out_valid;
   logic                out_ready;
`ifdef DECODER_STATS_EN
   logic [15:0]         stat_cnt;
`endif

   decoder_stream #(
      .IN_SIZE(IN_SIZE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_enable(in_enable),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out      (out),
      .out_valid(out_valid),
      .out_ready(out_ready)
`ifdef DECODER_STATS_EN
      ,
      .stat_cnt (stat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [OUT_SIZE-1:0] exp_q[$];
   logic [OUT_SIZE-1:0] rx_log[$];
   int                  rx_cyc[$];
   int                  exp_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rx_at(input int i);
      if (i >= 0 && i < rx_log.size()) return 32'(rx_log[i]);
      return 32'hDEAD_BEEF;
   endfunction

   // Model: the block is an in-order queue of at most two decoded words; the head is on out.
   always @(negedge clk) begin
      bit ohs, ihs;
      cyc++;
      if (rst) begin
         exp_q.delete();
         exp_cnt = 0;
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd1);
         check("rst_out", 32'(out), 32'd0);
      end else begin
         check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
         if (exp_q.size() != 0) check("out_word", 32'(out), 32'(exp_q[0]));
`ifdef DECODER_STATS_EN
         check("stat_cnt", 32'(stat_cnt), 32'(exp_cnt));
`endif
         ohs = (exp_q.size() != 0) && out_ready;
         ihs = in_valid && (exp_q.size() < 2);
         if (ohs) begin
            rx_log.push_back(out);
            rx_cyc.push_back(cyc);
            void'(exp_q.pop_front());
            if (exp_cnt < 65535) exp_cnt++;
         end
         if (ihs) exp_q.push_back(in_enable ? (OUT_SIZE'(1) << in_data) : '0);
      end
   end

   task automatic send(input logic [IN_SIZE-1:0] d, input logic en);
      bit ok = 0;
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = d;
      in_enable = en;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk); #1;
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rst       = 1'b1;
      in_data   = '0;
      in_enable = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("init_in_ready", 32'(in_ready), 32'd1);
      check("init_out_valid", 32'(out_valid), 32'd0);

      // Back-to-back stream at full rate
      out_ready = 1'b1;
      base = rx_log.size();
      for (int i = 0; i < 16; i++) send(4'(i), 1'b1);
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("stream_count", 32'(rx_log.size() - base), 32'd16);
      check("stream_first", rx_at(base), 32'h0001);
      check("stream_mid", rx_at(base + 5), 32'h0020);
      check("stream_last", rx_at(base + 15), 32'h8000);
      if (rx_cyc.size() >= base + 16)
         check("stream_no_bubble", 32'(rx_cyc[base+15] - rx_cyc[base]), 32'd15);
      else
         check("stream_no_bubble", 32'd0, 32'd15);

      // Disabled decode yields an all-zero word that is still valid
      base = rx_log.size();
      send(4'd5, 1'b0);
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("enable_count", 32'(rx_log.size() - base), 32'd1);
      check("enable_word", rx_at(base), 32'h0000);

      // Backpressure: two words fill the buffer, ready drops, head holds
      @(posedge clk); #1 out_ready = 1'b0;
      send(4'd3, 1'b1);
      send(4'd9, 1'b1);
      idle();
      @(negedge clk); #1;
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_head", 32'(out), 32'h0008);
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = 4'd7;
      in_enable = 1'b1;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk); #1;
      check("bp_out_stable", 32'(out), 32'h0008);
      check("bp_still_full", 32'(in_ready), 32'd0);
      base = rx_log.size();
      @(posedge clk); #1 out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("bp_drain_count", 32'(rx_log.size() - base), 32'd2);
      check("bp_drain_first", rx_at(base), 32'h0008);
      check("bp_drain_second", rx_at(base + 1), 32'h0200);
      check("bp_ready_back", 32'(in_ready), 32'd1);

      // Reset mid-operation discards buffered words immediately
      @(posedge clk); #1 out_ready = 1'b0;
      send(4'd1, 1'b1);
      send(4'd2, 1'b1);
      idle();
      @(posedge clk); #1 rst = 1'b1;
      #1;
      check("midrst_out", 32'(out), 32'h0000);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef DECODER_STATS_EN
      check("midrst_stat", 32'(stat_cnt), 32'd0);
`endif
      @(posedge clk); #1 rst = 1'b0;
      base = rx_log.size();
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_no_leftover", 32'(rx_log.size() - base), 32'd0);

`ifdef DECODER_STATS_EN
      // Counter saturation and clear
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = 4'd2;
      in_enable = 1'b1;
      repeat (70000) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("stat_saturated", 32'(stat_cnt), 32'h0000_FFFF);
      rst = 1'b1;
      #1;
      check("stat_cleared", 32'(stat_cnt), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
`endif

      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
